// File: rtl/pwm_pkg.sv
// ============================================================================
// pwm_pkg : shared types and constants for the PWM timebase block
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int PSC_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } pwm_state_e;

  // Functions-byte field: output alignment mode lives in bits [1:0]
  localparam int FN_ALIGN_LSB = 0;
  localparam int FN_ALIGN_W   = 2;

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_shadow_regs.sv
// ============================================================================
// pwm_shadow_regs : pending/active configuration bank with commit control
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pwm_shadow_regs
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_compare1,
  input  logic [CNT_W-1:0] cfg_compare2,
  input  logic [7:0]       cfg_functions,
  input  logic             cfg_dir_down,
  input  logic [PSC_W-1:0] cfg_prescale,
  input  logic             commit,
  output logic [CNT_W-1:0] pend_period,
  output logic             pend_dir_down,
  output logic [CNT_W-1:0] act_period,
  output logic [CNT_W-1:0] act_compare1,
  output logic [CNT_W-1:0] act_compare2,
  output logic [7:0]       act_functions,
  output logic             act_dir_down,
  output logic [PSC_W-1:0] act_prescale,
  output logic             cfg_pending
);

  logic [CNT_W-1:0] pper_q, pper_d, pcmp1_q, pcmp1_d, pcmp2_q, pcmp2_d;
  logic [7:0]       pfn_q, pfn_d;
  logic             pdir_q, pdir_d;
  logic [PSC_W-1:0] ppsc_q, ppsc_d;
  logic [CNT_W-1:0] aper_q, aper_d, acmp1_q, acmp1_d, acmp2_q, acmp2_d;
  logic [7:0]       afn_q, afn_d;
  logic             adir_q, adir_d;
  logic [PSC_W-1:0] apsc_q, apsc_d;
  logic             pend_q, pend_d;

  // Commit copies the pre-write pending contents; a write in the same clock
  // stays pending for the following commit.
  always_comb begin
    pper_d  = pper_q;
    pcmp1_d = pcmp1_q;
    pcmp2_d = pcmp2_q;
    pfn_d   = pfn_q;
    pdir_d  = pdir_q;
    ppsc_d  = ppsc_q;
    aper_d  = aper_q;
    acmp1_d = acmp1_q;
    acmp2_d = acmp2_q;
    afn_d   = afn_q;
    adir_d  = adir_q;
    apsc_d  = apsc_q;
    pend_d  = pend_q;
    if (commit) begin
      aper_d  = pper_q;
      acmp1_d = pcmp1_q;
      acmp2_d = pcmp2_q;
      afn_d   = pfn_q;
      adir_d  = pdir_q;
      apsc_d  = ppsc_q;
      pend_d  = 1'b0;
    end
    if (cfg_wr) begin
      pper_d  = cfg_period;
      pcmp1_d = cfg_compare1;
      pcmp2_d = cfg_compare2;
      pfn_d   = cfg_functions;
      pdir_d  = cfg_dir_down;
      ppsc_d  = cfg_prescale;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pper_q  <= '0;
      pcmp1_q <= '0;
      pcmp2_q <= '0;
      pfn_q   <= '0;
      pdir_q  <= 1'b0;
      ppsc_q  <= '0;
      aper_q  <= '0;
      acmp1_q <= '0;
      acmp2_q <= '0;
      afn_q   <= '0;
      adir_q  <= 1'b0;
      apsc_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      pper_q  <= pper_d;
      pcmp1_q <= pcmp1_d;
      pcmp2_q <= pcmp2_d;
      pfn_q   <= pfn_d;
      pdir_q  <= pdir_d;
      ppsc_q  <= ppsc_d;
      aper_q  <= aper_d;
      acmp1_q <= acmp1_d;
      acmp2_q <= acmp2_d;
      afn_q   <= afn_d;
      adir_q  <= adir_d;
      apsc_q  <= apsc_d;
      pend_q  <= pend_d;
    end
  end

  assign pend_period   = pper_q;
  assign pend_dir_down = pdir_q;
  assign act_period    = aper_q;
  assign act_compare1  = acmp1_q;
  assign act_compare2  = acmp2_q;
  assign act_functions = afn_q;
  assign act_dir_down  = adir_q;
  assign act_prescale  = apsc_q;
  assign cfg_pending   = pend_q;

endmodule : pwm_shadow_regs

`default_nettype wire

// File: rtl/pwm_timebase_ctrl.sv
// ============================================================================
// pwm_timebase_ctrl : prescaled up/down timebase with wrap-synchronous config
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pwm_timebase_ctrl
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cnt_clr,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_compare1,
  input  logic [CNT_W-1:0] cfg_compare2,
  input  logic [7:0]       cfg_functions,
  input  logic             cfg_dir_down,
  input  logic [PSC_W-1:0] cfg_prescale,
  output logic [CNT_W-1:0] count_val,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] compare1,
  output logic [CNT_W-1:0] compare2,
  output logic [7:0]       functions,
  output logic             pwm_en,
  output logic             wrap_pulse,
  output logic             upd_pulse,
  output logic             cfg_pending
);

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             wrap_q, wrap_d;
  logic             upd_q, upd_d;

  logic             commit;
  logic             tick;
  logic             at_wrap;
  logic [CNT_W-1:0] pend_period;
  logic             pend_dir_down;
  logic             act_dir_down;
  logic [PSC_W-1:0] act_prescale;
  logic             sel_dir;
  logic [CNT_W-1:0] sel_period;

  pwm_shadow_regs #(
    .CNT_W (CNT_W),
    .PSC_W (PSC_W)
  ) u_shadow (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_wr        (cfg_wr),
    .cfg_period    (cfg_period),
    .cfg_compare1  (cfg_compare1),
    .cfg_compare2  (cfg_compare2),
    .cfg_functions (cfg_functions),
    .cfg_dir_down  (cfg_dir_down),
    .cfg_prescale  (cfg_prescale),
    .commit        (commit),
    .pend_period   (pend_period),
    .pend_dir_down (pend_dir_down),
    .act_period    (period),
    .act_compare1  (compare1),
    .act_compare2  (compare2),
    .act_functions (functions),
    .act_dir_down  (act_dir_down),
    .act_prescale  (act_prescale),
    .cfg_pending   (cfg_pending)
  );

  // Reload values follow whatever configuration will be active after this edge
  assign sel_dir    = cfg_pending ? pend_dir_down : act_dir_down;
  assign sel_period = cfg_pending ? pend_period   : period;
  assign tick       = (state_q == ST_RUN) && (psc_q >= act_prescale);
  assign at_wrap    = act_dir_down ? (cnt_q == '0) : (cnt_q >= period);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    psc_d   = psc_q;
    wrap_d  = 1'b0;
    upd_d   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        psc_d  = '0;
        commit = cfg_pending;
        upd_d  = cfg_pending;
        if (en) state_d = ST_ARM;
      end
      ST_ARM: begin
        psc_d = '0;
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
          commit  = cfg_pending;
          upd_d   = cfg_pending;
          cnt_d   = sel_dir ? sel_period : '0;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          psc_d   = '0;
        end else if (cnt_clr) begin
          psc_d = '0;
          cnt_d = act_dir_down ? period : '0;
        end else if (tick) begin
          psc_d = '0;
          if (at_wrap) begin
            wrap_d = 1'b1;
            commit = cfg_pending;
            upd_d  = cfg_pending;
            cnt_d  = sel_dir ? sel_period : '0;
          end else begin
            cnt_d = act_dir_down ? (cnt_q - CNT_W'(1)) : (cnt_q + CNT_W'(1));
          end
        end else begin
          psc_d = psc_q + PSC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        psc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      psc_q   <= '0;
      wrap_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      psc_q   <= psc_d;
      wrap_q  <= wrap_d;
      upd_q   <= upd_d;
    end
  end

  // Pulses are registered so they line up with the count/config they announce
  assign count_val  = cnt_q;
  assign pwm_en     = (state_q == ST_RUN);
  assign wrap_pulse = wrap_q;
  assign upd_pulse  = upd_q;

endmodule : pwm_timebase_ctrl

`default_nettype wire

// File: tb/tb_pwm_timebase_ctrl.sv
// ============================================================================
// tb_pwm_timebase_ctrl : directed self-checking bench for pwm_timebase_ctrl
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pwm_timebase_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        cnt_clr;
  logic        cfg_wr;
  logic [15:0] cfg_period;
  logic [15:0] cfg_compare1;
  logic [15:0] cfg_compare2;
  logic [7:0]  cfg_functions;
  logic        cfg_dir_down;
  logic [7:0]  cfg_prescale;
  logic [15:0] count_val;
  logic [15:0] period;
  logic [15:0] compare1;
  logic [15:0] compare2;
  logic [7:0]  functions;
  logic        pwm_en;
  logic        wrap_pulse;
  logic        upd_pulse;
  logic        cfg_pending;

  int total = 0;
  int bad   = 0;

  pwm_timebase_ctrl #(.CNT_W(16), .PSC_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .cnt_clr       (cnt_clr),
    .cfg_wr        (cfg_wr),
    .cfg_period    (cfg_period),
    .cfg_compare1  (cfg_compare1),
    .cfg_compare2  (cfg_compare2),
    .cfg_functions (cfg_functions),
    .cfg_dir_down  (cfg_dir_down),
    .cfg_prescale  (cfg_prescale),
    .count_val     (count_val),
    .period        (period),
    .compare1      (compare1),
    .compare2      (compare2),
    .functions     (functions),
    .pwm_en        (pwm_en),
    .wrap_pulse    (wrap_pulse),
    .upd_pulse     (upd_pulse),
    .cfg_pending   (cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_cfg(input logic [15:0] per, input logic dn, input logic [7:0] psc);
    cfg_wr       = 1'b1;
    cfg_period   = per;
    cfg_dir_down = dn;
    cfg_prescale = psc;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cnt_clr = 1'b0; cfg_wr = 1'b0;
    cfg_period = '0; cfg_compare1 = '0; cfg_compare2 = '0;
    cfg_functions = '0; cfg_dir_down = 1'b0; cfg_prescale = '0;
    step(3);
    chk("rst_count", count_val, 0);
    chk("rst_period", period, 0);
    chk("rst_pwm_en", pwm_en, 0);
    chk("rst_wrap", wrap_pulse, 0);
    chk("rst_upd", upd_pulse, 0);
    chk("rst_pending", cfg_pending, 0);
    rst_n = 1'b1;
    step(1);

    // Basic up count, period 4, prescale 0
    wr_cfg(16'd4, 1'b0, 8'd0);
    cfg_compare1 = 16'd1; cfg_compare2 = 16'd3; cfg_functions = 8'hA5;
    step(1);
    cfg_wr = 1'b0;
    chk("idle_pending", cfg_pending, 1);
    chk("idle_period_old", period, 0);
    en = 1'b1;
    step(1);
    chk("arm_upd", upd_pulse, 1);
    chk("arm_period", period, 4);
    chk("arm_cmp1", compare1, 1);
    chk("arm_cmp2", compare2, 3);
    chk("arm_fn", functions, 8'hA5);
    chk("arm_pending_clr", cfg_pending, 0);
    chk("arm_pwm_en", pwm_en, 0);
    step(1);
    chk("run_pwm_en", pwm_en, 1);
    chk("run_cnt0", count_val, 0);
    chk("run_upd_low", upd_pulse, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk("up_seq", count_val, i);
      chk("up_seq_nowrap", wrap_pulse, 0);
    end
    step(1);
    chk("up_wrap_cnt", count_val, 0);
    chk("up_wrap_pulse", wrap_pulse, 1);
    step(1);
    chk("up_after_wrap", count_val, 1);
    chk("up_wrap_single", wrap_pulse, 0);

    // Switch to period 3, prescale 2: commit lands on the 4->0 wrap
    wr_cfg(16'd3, 1'b0, 8'd2);
    step(1);
    cfg_wr = 1'b0;
    chk("psc_cnt2", count_val, 2);
    step(2);
    chk("psc_cnt4_pend", cfg_pending, 1);
    step(1);
    chk("psc_commit_cnt", count_val, 0);
    chk("psc_commit_wrap", wrap_pulse, 1);
    chk("psc_commit_upd", upd_pulse, 1);
    chk("psc_commit_period", period, 3);
    step(2);
    chk("psc_hold0", count_val, 0);
    step(1);
    chk("psc_first_inc", count_val, 1);
    step(8);
    chk("psc_cnt3", count_val, 3);
    chk("psc_nowrap", wrap_pulse, 0);
    step(1);
    chk("psc_wrap12_cnt", count_val, 0);
    chk("psc_wrap12", wrap_pulse, 1);

    // Back to period 4 prescale 0, then mid-period write of period 9
    wr_cfg(16'd4, 1'b0, 8'd0);
    step(1);
    cfg_wr = 1'b0;
    step(11);
    chk("p4_commit_upd", upd_pulse, 1);
    chk("p4_commit_period", period, 4);
    step(2);
    chk("p4_cnt2", count_val, 2);
    wr_cfg(16'd9, 1'b0, 8'd0);
    step(1);
    cfg_wr = 1'b0;
    chk("p9_pending", cfg_pending, 1);
    chk("p9_period_old", period, 4);
    chk("p9_cnt3", count_val, 3);
    step(1);
    chk("p9_still_pending", cfg_pending, 1);
    step(1);
    chk("p9_wrap", wrap_pulse, 1);
    chk("p9_upd", upd_pulse, 1);
    chk("p9_period", period, 9);
    chk("p9_pending_clr", cfg_pending, 0);
    step(9);
    chk("p9_cnt9", count_val, 9);
    chk("p9_nowrap", wrap_pulse, 0);

    // Write on the wrap-tick clock itself is deferred to the next wrap
    wr_cfg(16'd5, 1'b0, 8'd0);
    step(1);
    cfg_wr = 1'b0;
    chk("late_wr_wrap", wrap_pulse, 1);
    chk("late_wr_noupd", upd_pulse, 0);
    chk("late_wr_period", period, 9);
    chk("late_wr_pending", cfg_pending, 1);
    step(10);
    chk("late_wr_wrap2", wrap_pulse, 1);
    chk("late_wr_upd2", upd_pulse, 1);
    chk("late_wr_period2", period, 5);

    // Down mode, period 3
    wr_cfg(16'd3, 1'b1, 8'd0);
    step(1);
    cfg_wr = 1'b0;
    step(5);
    chk("dn_commit_cnt", count_val, 3);
    chk("dn_commit_upd", upd_pulse, 1);
    step(1);
    chk("dn_cnt2", count_val, 2);
    step(2);
    chk("dn_cnt0", count_val, 0);
    chk("dn_cnt0_nowrap", wrap_pulse, 0);
    step(1);
    chk("dn_reload", count_val, 3);
    chk("dn_wrap", wrap_pulse, 1);

    // Down mode, period 0: wrap every tick
    wr_cfg(16'd0, 1'b1, 8'd0);
    step(1);
    cfg_wr = 1'b0;
    step(3);
    chk("p0_commit_cnt", count_val, 0);
    chk("p0_commit_upd", upd_pulse, 1);
    step(1);
    chk("p0_cnt", count_val, 0);
    chk("p0_wrap_a", wrap_pulse, 1);
    step(1);
    chk("p0_wrap_b", wrap_pulse, 1);
    chk("p0_upd_low", upd_pulse, 0);

    // Up, period 10; cnt_clr at 5 then en low at 3
    wr_cfg(16'd10, 1'b0, 8'd0);
    step(1);
    cfg_wr = 1'b0;
    step(1);
    chk("p10_commit_upd", upd_pulse, 1);
    chk("p10_commit_cnt", count_val, 0);
    step(5);
    chk("p10_cnt5", count_val, 5);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_cnt", count_val, 0);
    chk("clr_nowrap", wrap_pulse, 0);
    wr_cfg(16'd7, 1'b0, 8'd0);
    step(1);
    cfg_wr = 1'b0;
    step(2);
    chk("clr_cnt3", count_val, 3);
    en = 1'b0;
    step(1);
    chk("dis_cnt", count_val, 0);
    chk("dis_pwm_en", pwm_en, 0);
    chk("dis_nowrap", wrap_pulse, 0);
    chk("dis_pending", cfg_pending, 1);
    chk("dis_period", period, 10);
    step(1);
    chk("idle_commit_upd", upd_pulse, 1);
    chk("idle_commit_period", period, 7);

    // Asynchronous reset mid-run
    en = 1'b1;
    step(4);
    chk("rerun_pwm_en", pwm_en, 1);
    rst_n = 1'b0;
    #2;
    chk("arst_pwm_en", pwm_en, 0);
    chk("arst_count", count_val, 0);
    chk("arst_period", period, 0);
    step(1);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pwm_timebase_ctrl

`default_nettype wire
